// File: rtl/bss_pkg.sv
// Shared definitions for the bit-serial subtractor: the FSM state encoding
// and the default operand width.
package bss_pkg;

  localparam int BSS_WIDTH_DEF = 8;

  // 2'd3 is unused and decodes back to IDLE in the FSM.
  typedef enum logic [1:0] {
    BSS_IDLE  = 2'd0,
    BSS_SHIFT = 2'd1,
    BSS_DONE  = 2'd2
  } bss_state_t;

endpackage

// File: rtl/bit_serial_subtractor_fs_bit.sv
// fs_bit: combinational 1-bit full subtractor computing a - b - cin.
// d is the difference bit and bo is the borrow-out.
module fs_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic d,
  output logic bo
);

  // Borrow occurs when b exceeds a, or when a == b and a borrow comes in.
  always_comb begin
    d  = a ^ b ^ cin;
    bo = (~a & b) | (~(a ^ b) & cin);
  end

endmodule

// File: rtl/bit_serial_subtractor.sv
// bit_serial_subtractor: computes a_in - b_in - bin one bit per clock, LSB
// first, through a single fs_bit cell whose borrow is fed back through r_brw.
// Optional feature macro: BSS_OVF_EN adds the signed-overflow output ovf.
//
// Handshake: start is sampled only while ready=1 (state IDLE); that edge
// captures a_in/b_in/bin. busy is high through the WIDTH shift cycles, and
// done pulses for exactly one cycle when diff/bout (and ovf) are updated.
// start in any other state is ignored.
import bss_pkg::*;

module bit_serial_subtractor #(
  parameter int WIDTH = BSS_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef BSS_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);

  bss_state_t       r_state;
  bss_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  // Holds only the upper WIDTH-1 result bits; the newest bit arrives from
  // the cell each cycle and is merged in w_d_next.
  logic [WIDTH-2:0] r_d_sh;
  logic             r_brw;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             w_d;
  logic             w_bo;
  logic             w_last;
  logic [WIDTH-1:0] w_d_next;
`ifdef BSS_OVF_EN
  logic             r_msb_bin;
  logic             r_ovf;
`endif

  fs_bit u_fs_bit (
    .a   (r_a_sh[0]),
    .b   (r_b_sh[0]),
    .cin (r_brw),
    .d   (w_d),
    .bo  (w_bo)
  );

  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_d_next = {w_d, r_d_sh};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BSS_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; the unused encoding falls back to IDLE.
  always_comb begin
    w_state_nxt = BSS_IDLE;
    case (r_state)
      BSS_IDLE:  w_state_nxt = start ? BSS_SHIFT : BSS_IDLE;
      BSS_SHIFT: w_state_nxt = w_last ? BSS_DONE : BSS_SHIFT;
      BSS_DONE:  w_state_nxt = BSS_IDLE;
      default:   w_state_nxt = BSS_IDLE;
    endcase
  end

  // Operand capture, serial shifting and result load on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_d_sh    <= '0;
      r_brw     <= 1'b0;
      r_cnt     <= '0;
      r_diff    <= '0;
      r_bout    <= 1'b0;
`ifdef BSS_OVF_EN
      r_msb_bin <= 1'b0;
      r_ovf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        BSS_IDLE: begin
          if (start) begin
            r_a_sh <= a_in;
            r_b_sh <= b_in;
            r_brw  <= bin;
            r_cnt  <= '0;
          end
        end
        BSS_SHIFT: begin
          r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_d_sh <= w_d_next[WIDTH-1:1];
          r_brw  <= w_bo;
          r_cnt  <= r_cnt + CNT_W'(1);
`ifdef BSS_OVF_EN
          // Borrow produced by bit WIDTH-2 is the borrow into the MSB step.
          if (r_cnt == CNT_W'(WIDTH - 2)) r_msb_bin <= w_bo;
`endif
          if (w_last) begin
            r_diff <= w_d_next;
            r_bout <= w_bo;
`ifdef BSS_OVF_EN
            r_ovf  <= r_msb_bin ^ w_bo;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign ready     = (r_state == BSS_IDLE);
  assign busy      = (r_state == BSS_SHIFT);
  assign done      = (r_state == BSS_DONE);
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign dbg_state = r_state;
`ifdef BSS_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Testbench for bit_serial_subtractor (WIDTH=8). Directed vectors plus random
// operations checked against an arithmetic model of a - b - bin.
// Define BSS_OVF_EN for both bench and RTL to exercise ovf.
module tb_bit_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         bin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic [1:0]   dbg_state;

  int n_checks;
  int n_fail;
  logic [W-1:0] exp_q[$];

  bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .bin       (bin),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .bout      (bout),
`ifdef BSS_OVF_EN
    .ovf       (ovf),
`endif
    .dbg_state (dbg_state)
  );

`ifndef BSS_OVF_EN
  assign ovf = 1'b0;
`endif

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {bout,diff} = a - b - bin modulo 2^(W+1).
  function automatic logic [W:0] model_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    int r;
    r = int'(a) - int'(b) - int'(bi);
    return (W+1)'(r);
  endfunction

  // Signed result out of the W-bit two's-complement range.
  function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    int sr;
    sr = int'($signed(a)) - int'($signed(b)) - int'(bi);
    return (sr < -(1 << (W-1))) || (sr > ((1 << (W-1)) - 1));
  endfunction

  // Driver: wait for ready, pulse start, then wait for done. Returns the
  // number of cycles from the accept edge to done and the sampled result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        output int lat, output logic [W-1:0] d, output logic bo, output logic ov);
    int guard;
    guard = 0;
    while (ready !== 1'b1 && guard < 40) begin @(posedge clk); #1; guard++; end
    a_in = a; b_in = b; bin = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    d = diff; bo = bout; ov = ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; bin = 1'b0;
    #12;
    n_checks++;
    if ({ready, busy, done, diff, bout, ovf, dbg_state} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b busy=%b done=%b diff=%h bout=%b ovf=%b st=%0d, want 1 0 0 00 0 0 0",
               ready, busy, done, diff, bout, ovf, dbg_state);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int lat; logic [W-1:0] d; logic bo, ov;
    run_op(8'h5A, 8'h23, 1'b0, lat, d, bo, ov);
    n_checks++;
    if (lat !== 8) begin n_fail++; $display("FAIL lat_5a23: got %0d want 8", lat); end
    n_checks++;
    if ({bo, d} !== 9'h037) begin n_fail++; $display("FAIL res_5a23: got %b_%h want 0_37", bo, d); end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL done_pulse: got done=%b ready=%b want 0 1", done, ready);
    end
    run_op(8'h10, 8'h20, 1'b0, lat, d, bo, ov);
    n_checks++;
    if ({bo, d} !== 9'h1F0) begin n_fail++; $display("FAIL res_1020: got %b_%h want 1_f0", bo, d); end
    run_op(8'h00, 8'h00, 1'b1, lat, d, bo, ov);
    n_checks++;
    if ({bo, d} !== 9'h1FF) begin n_fail++; $display("FAIL res_bin: got %b_%h want 1_ff", bo, d); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [W-1:0] d; logic bo, ov;
    int gap;
    @(posedge clk); #1;
    // First op accepted here; start then stays high with new operands.
    a_in = 8'h5A; b_in = 8'h23; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a_in = 8'hFF; b_in = 8'h01;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (lat !== 8 || diff !== 8'h37) begin
      n_fail++; $display("FAIL b2b_first: got lat=%0d diff=%h want 8 37", lat, diff);
    end
    gap = 0;
    do begin @(posedge clk); #1; gap++; end while (done !== 1'b1 && gap < 40);
    start = 1'b0;
    // Ignored during DONE, accepted one edge later: WIDTH+2 between dones.
    n_checks++;
    if (gap !== 10) begin n_fail++; $display("FAIL b2b_gap: got %0d want 10", gap); end
    n_checks++;
    if ({bout, diff} !== 9'h0FE) begin n_fail++; $display("FAIL b2b_second: got %b_%h want 0_fe", bout, diff); end
    @(posedge clk); #1;
  endtask

  task automatic test_diff_hold();
    int lat; logic [W-1:0] d; logic bo, ov;
    int bad, cyc;
    run_op(8'h5A, 8'h23, 1'b0, lat, d, bo, ov);
    @(posedge clk); #1;
    a_in = 8'h10; b_in = 8'h20; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bad = 0; cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (diff !== 8'h37 || busy !== 1'b1) bad++;
      @(posedge clk); #1; cyc++;
    end
    n_checks++;
    if (bad !== 0 || cyc !== 8) begin
      n_fail++; $display("FAIL diff_hold: got bad=%0d cyc=%0d want 0 8", bad, cyc);
    end
    n_checks++;
    if (diff !== 8'hF0) begin n_fail++; $display("FAIL diff_update: got %h want f0", diff); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int lat; logic [W-1:0] d; logic bo, ov;
    a_in = 8'h5A; b_in = 8'h23; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ready, busy, done, diff, bout, ovf} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got rdy=%b busy=%b done=%b diff=%h bout=%b ovf=%b want 1 0 0 00 0 0",
               ready, busy, done, diff, bout, ovf);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h80, 8'h01, 1'b0, lat, d, bo, ov);
    n_checks++;
    if (lat !== 8 || {bo, d} !== 9'h07F) begin
      n_fail++; $display("FAIL post_reset: got lat=%0d res=%b_%h want 8 0_7f", lat, bo, d);
    end
  endtask

`ifdef BSS_OVF_EN
  task automatic test_ovf();
    int lat; logic [W-1:0] d; logic bo, ov;
    run_op(8'h80, 8'h01, 1'b0, lat, d, bo, ov);
    n_checks++;
    if ({ov, bo, d} !== 10'h27F) begin n_fail++; $display("FAIL ovf_8001: got ovf=%b %b_%h want 1 0_7f", ov, bo, d); end
    run_op(8'h05, 8'h03, 1'b0, lat, d, bo, ov);
    n_checks++;
    if ({ov, bo, d} !== 10'h002) begin n_fail++; $display("FAIL ovf_0503: got ovf=%b %b_%h want 0 0_02", ov, bo, d); end
    run_op(8'h7F, 8'hFF, 1'b0, lat, d, bo, ov);
    n_checks++;
    if ({ov, bo, d} !== 10'h380) begin n_fail++; $display("FAIL ovf_7fff: got ovf=%b %b_%h want 1 1_80", ov, bo, d); end
  endtask
`endif

  task automatic test_random();
    int lat; logic [W-1:0] d; logic bo, ov;
    logic [W-1:0] a, b; logic bi;
    logic [W:0] m;
    logic [W-1:0] e;
    for (int i = 0; i < 40; i++) begin
      a  = W'($urandom_range(0, 255));
      b  = W'($urandom_range(0, 255));
      bi = 1'($urandom_range(0, 1));
      if (i == 0) begin a = 8'hFF; b = 8'h00; bi = 1'b0; end
      if (i == 1) begin a = 8'h00; b = 8'hFF; bi = 1'b1; end
      m = model_sub(a, b, bi);
      exp_q.push_back(m[W-1:0]);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      run_op(a, b, bi, lat, d, bo, ov);
      e = exp_q.pop_front();
      n_checks++;
      if (lat !== 8 || d !== e || bo !== m[W]) begin
        n_fail++;
        $display("FAIL rand_%0d: %h-%h-%b got lat=%0d %b_%h want 8 %b_%h", i, a, b, bi, lat, bo, d, m[W], e);
      end
`ifdef BSS_OVF_EN
      n_checks++;
      if (ov !== model_ovf(a, b, bi)) begin
        n_fail++; $display("FAIL rand_ovf_%0d: got %b want %b", i, ov, model_ovf(a, b, bi));
      end
`endif
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_diff_hold();
    test_async_reset();
`ifdef BSS_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serial_subtractor.md
# bit_serial_subtractor

Multi-bit subtractor that computes `a_in - b_in - bin` one bit per clock, LSB first, by driving a single full-subtractor cell and feeding its borrow back through a register. It sits directly upstream of the full-subtractor cell: it sequences the cell's `a`/`b`/`cin` inputs, consumes its `D`/`B` outputs, and presents a registered WIDTH-bit result with a start/done handshake.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is WIDTH ≥ 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `start` input 1: request. Sampled only when `ready`=1.
- `a_in` input WIDTH: minuend. Captured on the accepting edge.
- `b_in` input WIDTH: subtrahend. Captured on the accepting edge.
- `bin` input 1: initial borrow-in. Captured on the accepting edge.
- `ready` output 1: block is idle and can accept `start`.
- `busy` output 1: serial subtraction in progress.
- `done` output 1: one-cycle pulse; the result was updated.
- `diff` output WIDTH: registered difference. Holds until the next completion.
- `bout` output 1: registered final borrow-out.
- `ovf` output 1: signed overflow flag. Present only with `BSS_OVF_EN`.

## Operation
- FSM states are IDLE, SHIFT and DONE.
  - `ready` = (state==IDLE).
  - `busy` = (state==SHIFT).
  - `done` = (state==DONE).
- **IDLE**
  - If `start`=1: load `a_sh`←`a_in`, `b_sh`←`b_in`, `brw`←`bin`, `cnt`←0, then go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT**, each cycle:
  - The cell computes `d`, `b` from (`a_sh[0]`, `b_sh[0]`, `brw`).
  - `a_sh`, `b_sh` shift right by one.
  - `d_sh` ← {`d`, `d_sh[WIDTH-1:1]`}.
  - `brw`←`b`.
  - `cnt`++.
  - When `cnt`==WIDTH-1: load `diff`←{`d`, `d_sh[WIDTH-1:1]`} and `bout`←`b`, then go to DONE.
- **DONE**: lasts one cycle, then unconditionally go to IDLE.
- Arithmetic:
  - Result is {`bout`, `diff`} = `a_in` − `b_in` − `bin`, modulo 2^(WIDTH+1) with borrow semantics.
  - `bout`=1 exactly when the unsigned `a_in` < `b_in` + `bin`.
- `cnt` is $clog2(WIDTH) bits wide. No wrap occurs because the exit condition is taken at WIDTH-1.
- `start` outside IDLE, including during DONE, is ignored. In-flight operands are unaffected.
- `diff` and `bout` change only on the edge that enters DONE. They are stable through a following operation until its completion.
- Reset (async, any state, including mid-SHIFT):
  - state=IDLE; `ready`=1; `busy`=0; `done`=0.
  - `diff`=0; `bout`=0; `ovf`=0.
  - All shift registers, `brw` and `cnt` are cleared.
  - A partially computed result is discarded.

## Timing
- Let E0 be the edge that samples `start`=1 in IDLE.
- Edges E1..E_WIDTH each process one bit.
- `done`=1 and the new `diff`/`bout` are visible for the one cycle after E_WIDTH, i.e. WIDTH cycles after E0.
- `ready` returns to 1 after E_WIDTH+1.
- Back-to-back throughput: one result per WIDTH+2 cycles. This is the earliest next accept edge relative to the previous E0.
- No combinational path exists from inputs to outputs. All outputs are registers or decodes of registered state.

## Configuration
- `BSS_OVF_EN` defined:
  - Port `ovf` exists.
  - A register `msb_bin` captures `brw` at the start of the MSB step (`cnt`==WIDTH-1).
  - `ovf` ← `msb_bin` ^ `b`, loaded together with `diff`, with the same hold and reset rules.
  - This is two's-complement overflow of `a_in` − `b_in` − `bin`.
- `BSS_OVF_EN` undefined: the `ovf` port, the `msb_bin` register and their logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package `bss_pkg` holds:
  - the state encoding constants `BSS_IDLE`=2'd0, `BSS_SHIFT`=2'd1, `BSS_DONE`=2'd2;
  - the default WIDTH constant.
- Unused encoding 2'd3 returns to IDLE.
- One sub-module, `fs_bit`: a combinational 1-bit full subtractor.
  - Inputs `a`, `b`, `cin`; outputs `d`, `bo`.
  - `d` = a^b^cin.
  - `bo` = (~a&b) | (~(a^b)&cin).
  - Instantiated once.

## Test plan
All scenarios use WIDTH=8.
1. `a_in`=0x5A, `b_in`=0x23, `bin`=0, one-cycle `start` → `done` pulses exactly 8 cycles after the accept edge; `diff`=0x37, `bout`=0.
2. `a_in`=0x10, `b_in`=0x20, `bin`=0 → `diff`=0xF0, `bout`=1. Then `a_in`=0x00, `b_in`=0x00, `bin`=1 → `diff`=0xFF, `bout`=1.
3. Accept 0x5A−0x23. Then hold `start`=1 with `a_in`=0xFF, `b_in`=0x01 during SHIFT and DONE → first result 0x37 is reported. The second operation is accepted only on the first edge with `ready`=1 and yields `diff`=0xFE.
4. Drop `rst_n` asynchronously after the 4th SHIFT edge → all outputs immediately zero, `ready`=1. After release, 0x80−0x01 completes with `diff`=0x7F, `bout`=0.
5. Hold `diff`: complete 0x5A−0x23, then start 0x10−0x20 → `diff` stays 0x37 throughout SHIFT and changes to 0xF0 exactly when `done` rises.
6. With `BSS_OVF_EN`:
   - 0x80−0x01 with `bin`=0 → `diff`=0x7F, `bout`=0, `ovf`=1.
   - 0x05−0x03 → `diff`=0x02, `ovf`=0.
   - 0x7F−0xFF → `diff`=0x80, `bout`=1, `ovf`=1.
